// File: rtl/bounce_pos_reg_pkg.sv
// Shared types and constants for the bounce position register slice.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic DIR_MIN = 1'b0;
  localparam logic DIR_MAX = 1'b1;

  localparam logic BOUNCE = 1'b0;
  localparam logic WRAP   = 1'b1;

endpackage

// File: rtl/bounce_pos_reg_if.sv
// Control/status bundle between the game FSM (master) and bounce_pos_reg (slave).
// BOUNCE_CNT_EN adds the bounce_cnt status field.
interface bounce_pos_reg_if #(
  parameter int WIDTH  = 8,
  parameter int DIV_W  = 4,
  parameter int STEP_W = 3
);
  logic              sync;
  logic              load;
  logic [WIDTH-1:0]  load_pos;
  logic              load_dir;
  logic              start;
  logic              stop;
  logic              wrap_mode;
  logic [WIDTH-1:0]  min_pos;
  logic [WIDTH-1:0]  max_pos;
  logic [STEP_W-1:0] step;
  logic [DIV_W-1:0]  div;
  logic [WIDTH-1:0]  pos;
  logic              dir;
  logic              running;
  logic              edge_hit;
  logic              halted;
`ifdef BOUNCE_CNT_EN
  logic [7:0]        bounce_cnt;
`endif

  modport master (
    output sync, load, load_pos, load_dir, start, stop, wrap_mode,
           min_pos, max_pos, step, div,
`ifdef BOUNCE_CNT_EN
    input  bounce_cnt,
`endif
    input  pos, dir, running, edge_hit, halted
  );

  modport slave (
    input  sync, load, load_pos, load_dir, start, stop, wrap_mode,
           min_pos, max_pos, step, div,
`ifdef BOUNCE_CNT_EN
    output bounce_cnt,
`endif
    output pos, dir, running, edge_hit, halted
  );

endinterface

// File: rtl/bounce_pos_reg_tick_divider.sv
// Frame-tick edge detector plus speed divider; move_en pulses on every (div+1)-th tick while enabled.
module tick_divider #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             move_en
);

  logic             sync_q;
  logic [DIV_W-1:0] cnt;
  logic             tick;

  assign tick    = sync & ~sync_q;
  assign move_en = en & tick & (cnt == div);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= sync;
      if (clr)
        cnt <= '0;
      else if (en && tick)
        cnt <= (cnt == div) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bounce_pos_reg.sv
// 1-D position register with bounce/wrap limits, speed divider and IDLE/RUN/HALT control.
// BOUNCE_CNT_EN adds a saturating edge-hit counter on bus.bounce_cnt.
module bounce_pos_reg
  import bounce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIV_W  = 4,
  parameter int STEP_W = 3
) (
  input logic             clk,
  input logic             reset,
  bounce_pos_reg_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pos_q, pos_nxt;
  logic             dir_q, dir_nxt;
  logic             hit_q, hit_nxt;
  logic             halt_q, halt_nxt;
  logic             move_en;

  logic [WIDTH-1:0] step_w;
  logic [WIDTH:0]   up;
  logic [WIDTH:0]   floor_lim;
  logic [WIDTH-1:0] dn;
  logic [WIDTH-1:0] mv_pos;
  logic             mv_dir;
  logic             mv_hit;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .reset   (reset),
    .sync    (bus.sync),
    .en      (state == RUN),
    .clr     (bus.load),
    .div     (bus.div),
    .move_en (move_en)
  );

  assign step_w    = {{(WIDTH-STEP_W){1'b0}}, bus.step};
  assign up        = {1'b0, pos_q} + {1'b0, step_w};
  assign floor_lim = {1'b0, bus.min_pos} + {1'b0, step_w};
  assign dn        = pos_q - step_w;

  // Down-moves test pos < min+step so the subtraction never goes below zero.
  always_comb begin
    mv_pos = pos_q;
    mv_dir = dir_q;
    mv_hit = 1'b0;
    if (bus.min_pos == bus.max_pos) begin
      mv_pos = bus.min_pos;
      mv_hit = 1'b1;
      if (bus.wrap_mode == BOUNCE) mv_dir = ~dir_q;
    end else if (bus.step != '0) begin
      if (bus.wrap_mode == BOUNCE) begin
        if (dir_q == DIR_MAX) begin
          if (up >= {1'b0, bus.max_pos}) begin
            mv_pos = bus.max_pos; mv_dir = DIR_MIN; mv_hit = 1'b1;
          end else mv_pos = up[WIDTH-1:0];
        end else begin
          if ({1'b0, pos_q} < floor_lim) begin
            mv_pos = bus.min_pos; mv_dir = DIR_MAX; mv_hit = 1'b1;
          end else mv_pos = dn;
        end
      end else begin
        if (dir_q == DIR_MAX) begin
          if (up > {1'b0, bus.max_pos}) begin
            mv_pos = bus.min_pos; mv_hit = 1'b1;
          end else mv_pos = up[WIDTH-1:0];
        end else begin
          if ({1'b0, pos_q} < floor_lim) begin
            mv_pos = bus.max_pos; mv_hit = 1'b1;
          end else mv_pos = dn;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos_q;
    dir_nxt   = dir_q;
    hit_nxt   = 1'b0;
    halt_nxt  = 1'b0;
    if (bus.load) begin
      state_nxt = IDLE;
      dir_nxt   = bus.load_dir;
      if (bus.load_pos < bus.min_pos)      pos_nxt = bus.min_pos;
      else if (bus.load_pos > bus.max_pos) pos_nxt = bus.max_pos;
      else                                 pos_nxt = bus.load_pos;
    end else begin
      unique case (state)
        IDLE: if (bus.start) state_nxt = RUN;
        RUN: begin
          if (bus.stop) begin
            state_nxt = HALT;
            halt_nxt  = 1'b1;
          end else if (move_en) begin
            pos_nxt = mv_pos;
            dir_nxt = mv_dir;
            hit_nxt = mv_hit;
          end
        end
        HALT: state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pos_q  <= bus.min_pos;
      dir_q  <= DIR_MAX;
      hit_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pos_q  <= pos_nxt;
      dir_q  <= dir_nxt;
      hit_q  <= hit_nxt;
      halt_q <= halt_nxt;
    end
  end

`ifdef BOUNCE_CNT_EN
  logic [7:0] bcnt_q;
  always_ff @(posedge clk) begin
    if (reset || bus.load)
      bcnt_q <= '0;
    else if (hit_nxt && bcnt_q != 8'hFF)
      bcnt_q <= bcnt_q + 8'd1;
  end
  assign bus.bounce_cnt = bcnt_q;
`endif

  assign bus.pos      = pos_q;
  assign bus.dir      = dir_q;
  assign bus.running  = (state == RUN);
  assign bus.edge_hit = hit_q;
  assign bus.halted   = halt_q;

endmodule

// File: tb/tb_bounce_pos_reg.sv
// Self-checking bench for bounce_pos_reg: vector table plus hand-written multi-cycle sequences.
module tb_bounce_pos_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bounce_pos_reg_if bus ();
  bounce_pos_reg dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] pos;
    logic       dir;
    logic       hit;
    logic       run;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string      name;
    logic       wrap;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] lp;
    logic       ld;
    logic [2:0] st;
    logic [3:0] dv;
    int         nt;
    logic [7:0] ep;
    logic       ed;
    logic       eh;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input string nm, input int p, input logic d, input logic h, input logic r);
    exp_t e;
    e.name = nm; e.pos = p[7:0]; e.dir = d; e.hit = h; e.run = r;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({e.name, ".pos"}, {24'd0, bus.pos}, {24'd0, e.pos});
    chk({e.name, ".dir"}, {31'd0, bus.dir}, {31'd0, e.dir});
    chk({e.name, ".hit"}, {31'd0, bus.edge_hit}, {31'd0, e.hit});
    chk({e.name, ".run"}, {31'd0, bus.running}, {31'd0, e.run});
  endtask

  task automatic set_cfg(input logic w, input logic [7:0] mn, input logic [7:0] mx,
                         input logic [2:0] st, input logic [3:0] dv);
    bus.wrap_mode = w; bus.min_pos = mn; bus.max_pos = mx; bus.step = st; bus.div = dv;
  endtask

  task automatic do_load(input logic [7:0] p, input logic d);
    bus.load = 1'b1; bus.load_pos = p; bus.load_dir = d;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  // One-cycle sync pulse; outputs of the resulting move are visible at the first negedge.
  task automatic tick(input bit do_check);
    bus.sync = 1'b1;
    cyc();
    if (do_check) pop_cmp();
    bus.sync = 1'b0;
    cyc();
  endtask

  initial begin
    vt[0]  = '{"b_up3",      1'b0, 8'd0,  8'd144, 8'd10,  1'b1, 3'd1, 4'd0, 3, 8'd13,  1'b1, 1'b0};
    vt[1]  = '{"b_hitmax",   1'b0, 8'd0,  8'd144, 8'd143, 1'b1, 3'd3, 4'd0, 1, 8'd144, 1'b0, 1'b1};
    vt[2]  = '{"b_after",    1'b0, 8'd0,  8'd144, 8'd143, 1'b1, 3'd3, 4'd0, 2, 8'd141, 1'b0, 1'b0};
    vt[3]  = '{"b_eqmax",    1'b0, 8'd0,  8'd144, 8'd141, 1'b1, 3'd3, 4'd0, 1, 8'd144, 1'b0, 1'b1};
    vt[4]  = '{"w_over",     1'b1, 8'd0,  8'd144, 8'd143, 1'b1, 3'd3, 4'd0, 1, 8'd0,   1'b1, 1'b1};
    vt[5]  = '{"w_eqmax",    1'b1, 8'd0,  8'd144, 8'd141, 1'b1, 3'd3, 4'd0, 1, 8'd144, 1'b1, 1'b0};
    vt[6]  = '{"w_under",    1'b1, 8'd0,  8'd144, 8'd2,   1'b0, 3'd3, 4'd0, 1, 8'd144, 1'b0, 1'b1};
    vt[7]  = '{"w_255",      1'b1, 8'd0,  8'd255, 8'd254, 1'b1, 3'd3, 4'd0, 1, 8'd0,   1'b1, 1'b1};
    vt[8]  = '{"b_down",     1'b0, 8'd10, 8'd100, 8'd12,  1'b0, 3'd2, 4'd0, 1, 8'd10,  1'b0, 1'b0};
    vt[9]  = '{"b_hitmin",   1'b0, 8'd10, 8'd100, 8'd12,  1'b0, 3'd2, 4'd0, 2, 8'd10,  1'b1, 1'b1};
    vt[10] = '{"clamp_lo",   1'b0, 8'd10, 8'd100, 8'd5,   1'b1, 3'd4, 4'd0, 0, 8'd10,  1'b1, 1'b0};
    vt[11] = '{"clamp_hi",   1'b0, 8'd10, 8'd100, 8'd250, 1'b0, 3'd4, 4'd0, 0, 8'd100, 1'b0, 1'b0};
    vt[12] = '{"min_eq_max", 1'b0, 8'd50, 8'd50,  8'd50,  1'b1, 3'd1, 4'd0, 1, 8'd50,  1'b0, 1'b1};
    vt[13] = '{"div2_2",     1'b0, 8'd0,  8'd144, 8'd20,  1'b1, 3'd1, 4'd2, 2, 8'd20,  1'b1, 1'b0};
    vt[14] = '{"div2_3",     1'b0, 8'd0,  8'd144, 8'd20,  1'b1, 3'd1, 4'd2, 3, 8'd21,  1'b1, 1'b0};
    vt[15] = '{"step0",      1'b0, 8'd0,  8'd144, 8'd30,  1'b1, 3'd0, 4'd0, 3, 8'd30,  1'b1, 1'b0};
    vt[16] = '{"b_down_div", 1'b0, 8'd0,  8'd144, 8'd100, 1'b0, 3'd5, 4'd1, 4, 8'd90,  1'b0, 1'b0};
    vt[17] = '{"w_down_eq",  1'b1, 8'd0,  8'd144, 8'd3,   1'b0, 3'd3, 4'd0, 1, 8'd0,   1'b0, 1'b0};

    bus.sync = 1'b0; bus.load = 1'b0; bus.load_pos = '0; bus.load_dir = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    set_cfg(1'b0, 8'd7, 8'd100, 3'd1, 4'd0);
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("reset.pos", {24'd0, bus.pos}, 32'd7);
    chk("reset.dir", {31'd0, bus.dir}, 32'd1);
    chk("reset.run", {31'd0, bus.running}, 32'd0);
    chk("reset.hit", {31'd0, bus.edge_hit}, 32'd0);
    chk("reset.halted", {31'd0, bus.halted}, 32'd0);
`ifdef BOUNCE_CNT_EN
    chk("reset.bcnt", {24'd0, bus.bounce_cnt}, 32'd0);
`endif
    // start is ignored outside IDLE only; ticks in IDLE must not move
    tick(1'b0);
    chk("idle_hold.pos", {24'd0, bus.pos}, 32'd7);

    foreach (vt[i]) begin
      set_cfg(vt[i].wrap, vt[i].mn, vt[i].mx, vt[i].st, vt[i].dv);
      do_load(vt[i].lp, vt[i].ld);
      do_start();
      if (vt[i].nt == 0) begin
        push(vt[i].name, int'(vt[i].ep), vt[i].ed, vt[i].eh, 1'b1);
        pop_cmp();
      end else begin
        for (int k = 0; k < vt[i].nt; k++) begin
          if (k == vt[i].nt - 1) begin
            push(vt[i].name, int'(vt[i].ep), vt[i].ed, vt[i].eh, 1'b1);
            tick(1'b1);
          end else begin
            tick(1'b0);
          end
        end
      end
    end

    // Sequence 1: step 1 per tick from 10
    set_cfg(1'b0, 8'd0, 8'd144, 3'd1, 4'd0);
    do_load(8'd10, 1'b1);
    do_start();
    for (int k = 1; k <= 3; k++) begin
      push("seq1", 10 + k, 1'b1, 1'b0, 1'b1);
      tick(1'b1);
    end

    // Sequence 2: bounce at max, edge_hit single-cycle, then move back down
    set_cfg(1'b0, 8'd0, 8'd144, 3'd3, 4'd0);
    do_load(8'd143, 1'b1);
    do_start();
    push("seq2_hit", 144, 1'b0, 1'b1, 1'b1);
    tick(1'b1);
    chk("seq2.hit_width", {31'd0, bus.edge_hit}, 32'd0);
`ifdef BOUNCE_CNT_EN
    chk("seq2.bcnt", {24'd0, bus.bounce_cnt}, 32'd1);
`endif
    push("seq2_back", 141, 1'b0, 1'b0, 1'b1);
    tick(1'b1);

    // Sequence 4: div=2, long sync high is a single tick; moves on ticks 3,6,9
    set_cfg(1'b0, 8'd0, 8'd144, 3'd1, 4'd2);
    do_load(8'd20, 1'b1);
    do_start();
    bus.sync = 1'b1;
    repeat (10) cyc();
    bus.sync = 1'b0;
    cyc();
    chk("seq4.long_sync", {24'd0, bus.pos}, 32'd20);
    for (int k = 2; k <= 9; k++) begin
      push("seq4", 20 + k / 3, 1'b1, 1'b0, 1'b1);
      tick(1'b1);
    end

    // Sequence 5: stop coincides with a move at pos 50
    set_cfg(1'b0, 8'd0, 8'd144, 3'd1, 4'd0);
    do_load(8'd50, 1'b1);
    do_start();
    bus.sync = 1'b1; bus.stop = 1'b1;
    cyc();
    bus.sync = 1'b0; bus.stop = 1'b0;
    chk("seq5.pos", {24'd0, bus.pos}, 32'd50);
    chk("seq5.halted", {31'd0, bus.halted}, 32'd1);
    chk("seq5.run", {31'd0, bus.running}, 32'd0);
    cyc();
    chk("seq5.halted_width", {31'd0, bus.halted}, 32'd0);
    tick(1'b0); tick(1'b0);
    do_start();
    chk("seq5.start_in_halt", {31'd0, bus.running}, 32'd0);
    chk("seq5.frozen", {24'd0, bus.pos}, 32'd50);
    do_load(8'd60, 1'b1);
    do_start();
    push("seq5_reload", 61, 1'b1, 1'b0, 1'b1);
    tick(1'b1);

    // Sequence 6: out-of-range load during RUN clamps and clears the divider
    set_cfg(1'b0, 8'd0, 8'd144, 3'd1, 4'd2);
    do_load(8'd20, 1'b1);
    do_start();
    tick(1'b0);
    do_load(8'd200, 1'b0);
    chk("seq6.pos", {24'd0, bus.pos}, 32'd144);
    chk("seq6.run", {31'd0, bus.running}, 32'd0);
`ifdef BOUNCE_CNT_EN
    chk("seq6.bcnt", {24'd0, bus.bounce_cnt}, 32'd0);
`endif
    do_start();
    tick(1'b0);
    push("seq6_div_cleared", 144, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    push("seq6_move", 143, 1'b0, 1'b0, 1'b1);
    tick(1'b1);

    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
